// File: rtl/alu_exec_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_exec_pkg                                              |
// | Purpose  : Shared opcode/bonus constants, FSM state type and the     |
// |            operand magnitude helper for the execute-stage ALU.       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package alu_exec_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1011;
  localparam logic [3:0] OP_SHIFT = 4'b1111;

  localparam logic [2:0] BONUS_NONE = 3'b000;
  localparam logic [2:0] BONUS_JR   = 3'b010;
  localparam logic [2:0] BONUS_SRL  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Magnitude of a signed 32-bit value. Negation is done in 33 bits so that
  // 0x80000000 yields +2^31, which fits the 32-bit unsigned result.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    logic [32:0] ext;
    ext = {v[31], v};
    if (v[31]) ext = ~ext + 33'd1;
    return ext[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_unit_seq_multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seq_multiplier                                            |
// | Purpose  : 32x32 unsigned shift-add multiplier, one partial product  |
// |            per cycle, 32 cycles per product.                         |
// | Ports    : clk_i, rst_i (async, active-low), start_i, a_i, b_i,      |
// |            busy_o, done_o (final-step strobe), product_o             |
// | Note     : product_o is the accumulator including the current step,  |
// |            so it is the complete product while done_o is high.       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module seq_multiplier (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] product_o
);

  logic [63:0] mcand_q;
  logic [63:0] acc_q;
  logic [63:0] acc_d;
  logic [31:0] mplier_q;
  logic [5:0]  cnt_q;
  logic        busy_q;

  assign acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign product_o = acc_d;
  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == 6'd31);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i && !busy_q) begin
      mcand_q  <= {32'd0, a_i};
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 6'd1;
      if (cnt_q == 6'd31) busy_q <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_exec_unit                                             |
// | Purpose  : Execute-stage ALU. Logic/arith/shift ops finish in one    |
// |            registered cycle; signed MUL runs 32 shift-add steps with |
// |            a busy/done handshake for EX-stage stalling.              |
// | Ports    : clk_i, rst_i (async, active-low), start_i, ALUCtrl_i,     |
// |            BonusCtrl_i, ALUShift_i, src1_i, src2_i, shamt_i ->       |
// |            result_o, hi_o, zero_o, overflow_o, busy_o, done_o        |
// | Config   : ALU_EXEC_MUL_EN builds the iterative multiplier; without  |
// |            it opcode 1011 completes in one cycle with result 0.      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module alu_exec_unit
  import alu_exec_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [3:0]  ALUCtrl_i,
  input  logic [2:0]  BonusCtrl_i,
  input  logic        ALUShift_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] result_o,
  output logic [31:0] hi_o,
  output logic        zero_o,
  output logic        overflow_o,
  output logic        busy_o,
  output logic        done_o
);

  state_t      state_q;
  logic [31:0] result_q;
  logic [31:0] hi_q;
  logic        zero_q;
  logic        ovf_q;
  logic        busy_q;
  logic        done_q;

  logic [31:0] sum_d;
  logic [31:0] diff_d;
  logic [4:0]  shamt_d;
  logic [31:0] alu_res_d;
  logic        alu_ovf_d;

  assign sum_d   = src1_i + src2_i;
  assign diff_d  = src1_i - src2_i;
  assign shamt_d = ALUShift_i ? shamt_i : src1_i[4:0];

  always_comb begin
    alu_res_d = '0;
    alu_ovf_d = 1'b0;
    case (ALUCtrl_i)
      OP_AND: alu_res_d = src1_i & src2_i;
      OP_OR:  alu_res_d = src1_i | src2_i;
      OP_ADD: begin
        if (BonusCtrl_i == BONUS_JR) begin
          alu_res_d = src1_i;  // jump-register target pass-through
        end else begin
          alu_res_d = sum_d;
          alu_ovf_d = (src1_i[31] == src2_i[31]) && (sum_d[31] != src1_i[31]);
        end
      end
      OP_SUB: begin
        alu_res_d = diff_d;
        alu_ovf_d = (src1_i[31] != src2_i[31]) && (diff_d[31] != src1_i[31]);
      end
      OP_SLT: alu_res_d = {31'd0, ($signed(src1_i) < $signed(src2_i))};
      OP_SHIFT: begin
        case (BonusCtrl_i)
          BONUS_SRL:  alu_res_d = src2_i >> shamt_d;
          BONUS_NONE: alu_res_d = src2_i << shamt_d;
          default:    alu_res_d = src2_i << shamt_d;
        endcase
      end
      default: alu_res_d = '0;  // unsupported codes (and MUL when not built)
    endcase
  end

`ifdef ALU_EXEC_MUL_EN
  logic        sign_q;
  logic        mul_start_d;
  logic        mul_busy;
  logic        mul_done;
  logic [63:0] mul_prod;
  logic [63:0] prod_signed_d;

  assign mul_start_d   = (state_q == ST_IDLE) && start_i && (ALUCtrl_i == OP_MUL);
  assign prod_signed_d = sign_q ? (~mul_prod + 64'd1) : mul_prod;

  seq_multiplier u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (mul_start_d),
    .a_i       (mag32(src1_i)),
    .b_i       (mag32(src2_i)),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      sign_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
`ifdef ALU_EXEC_MUL_EN
            if (ALUCtrl_i == OP_MUL) begin
              state_q <= ST_MUL;
              busy_q  <= 1'b1;
              sign_q  <= src1_i[31] ^ src2_i[31];
            end else
`endif
            begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              result_q <= alu_res_d;
              zero_q   <= (alu_res_d == 32'd0);
              ovf_q    <= alu_ovf_d;
            end
          end
        end
`ifdef ALU_EXEC_MUL_EN
        ST_MUL: begin
          // mul_done marks the 32nd step; its product already includes it.
          if (mul_done && mul_busy) begin
            {hi_q, result_q} <= prod_signed_d;
            zero_q  <= (prod_signed_d[31:0] == 32'd0);
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
`endif
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign result_o   = result_q;
  assign hi_o       = hi_q;
  assign zero_o     = zero_q;
  assign overflow_o = ovf_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_alu_exec_unit                                          |
// | Purpose  : Directed self-checking bench for alu_exec_unit. MUL       |
// |            expectations follow ALU_EXEC_MUL_EN.                      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_alu_exec_unit;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [3:0]  ALUCtrl_i;
  logic [2:0]  BonusCtrl_i;
  logic        ALUShift_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic [4:0]  shamt_i;
  logic [31:0] result_o;
  logic [31:0] hi_o;
  logic        zero_o;
  logic        overflow_o;
  logic        busy_o;
  logic        done_o;

  int checks   = 0;
  int failures = 0;

  alu_exec_unit dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .ALUCtrl_i   (ALUCtrl_i),
    .BonusCtrl_i (BonusCtrl_i),
    .ALUShift_i  (ALUShift_i),
    .src1_i      (src1_i),
    .src2_i      (src2_i),
    .shamt_i     (shamt_i),
    .result_o    (result_o),
    .hi_o        (hi_o),
    .zero_o      (zero_o),
    .overflow_o  (overflow_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Waits one cycle so the unit is back in IDLE, drives a one-cycle start,
  // and returns #1 after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [2:0] bon, input logic sh,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] sa);
    @(posedge clk_i); #1;
    ALUCtrl_i = op; BonusCtrl_i = bon; ALUShift_i = sh;
    src1_i = a; src2_i = b; shamt_i = sa; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  int busy_cycles;
  int done_seen;

  initial begin
    rst_i = 1'b0; start_i = 1'b0; ALUCtrl_i = '0; BonusCtrl_i = '0;
    ALUShift_i = 1'b0; src1_i = '0; src2_i = '0; shamt_i = '0;
    repeat (2) @(posedge clk_i); #1;
    chk32("rst_result", result_o, 32'h0);
    chk32("rst_hi", hi_o, 32'h0);
    chk1("rst_zero", zero_o, 1'b0);
    chk1("rst_ovf", overflow_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_done", done_o, 1'b0);
    @(negedge clk_i); rst_i = 1'b1;

    issue(4'b0010, 3'b000, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
    chk1("add_done", done_o, 1'b1);
    chk1("add_busy", busy_o, 1'b0);
    chk32("add_result", result_o, 32'h8000_0000);
    chk1("add_ovf", overflow_o, 1'b1);
    chk1("add_zero", zero_o, 1'b0);
    @(posedge clk_i); #1;
    chk1("add_done_pulse", done_o, 1'b0);
    chk32("add_hold", result_o, 32'h8000_0000);

    issue(4'b0110, 3'b000, 1'b0, 32'd5, 32'd5, 5'd0);
    chk32("sub_result", result_o, 32'h0);
    chk1("sub_zero", zero_o, 1'b1);
    chk1("sub_ovf", overflow_o, 1'b0);

    issue(4'b0110, 3'b000, 1'b0, 32'h8000_0000, 32'h0000_0001, 5'd0);
    chk32("subovf_result", result_o, 32'h7FFF_FFFF);
    chk1("subovf_ovf", overflow_o, 1'b1);

    issue(4'b0111, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
    chk32("slt_neg", result_o, 32'h1);
    issue(4'b0111, 3'b000, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0);
    chk32("slt_pos", result_o, 32'h0);
    chk1("slt_zero", zero_o, 1'b1);

    issue(4'b0000, 3'b000, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 5'd0);
    chk32("and", result_o, 32'h0000_F000);
    issue(4'b0001, 3'b000, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 5'd0);
    chk32("or", result_o, 32'h0000_FFF0);

    issue(4'b0010, 3'b010, 1'b0, 32'h1234_5678, 32'h0000_0005, 5'd0);
    chk32("jr_pass", result_o, 32'h1234_5678);

    issue(4'b1111, 3'b101, 1'b1, 32'h0, 32'hF000_0000, 5'd4);
    chk32("srl_shamt", result_o, 32'h0F00_0000);
    issue(4'b1111, 3'b000, 1'b0, 32'd35, 32'h0000_0001, 5'd0);
    chk32("sll_src1", result_o, 32'h0000_0008);
    issue(4'b1111, 3'b101, 1'b1, 32'h0, 32'h0000_ABCD, 5'd0);
    chk32("shift_zero", result_o, 32'h0000_ABCD);

    issue(4'b0011, 3'b000, 1'b0, 32'h1111_1111, 32'h2222_2222, 5'd0);
    chk32("undef_op", result_o, 32'h0);
    chk1("undef_zero", zero_o, 1'b1);
    chk32("hi_untouched", hi_o, 32'h0);

`ifdef ALU_EXEC_MUL_EN
    issue(4'b1011, 3'b000, 1'b0, 32'hFFFF_FFFD, 32'h0000_0005, 5'd0);
    busy_cycles = 0;
    for (int i = 0; i < 40 && !done_o; i++) begin
      if (busy_o) busy_cycles++;
      if (i == 5) begin
        ALUCtrl_i = 4'b0010; src1_i = 32'd1; src2_i = 32'd1; start_i = 1'b1;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk_i); #1;
    end
    start_i = 1'b0;
    chk32("mul_busy_cycles", busy_cycles, 32'd32);
    chk1("mul_done", done_o, 1'b1);
    chk1("mul_busy_low", busy_o, 1'b0);
    chk32("mul_hi", hi_o, 32'hFFFF_FFFF);
    chk32("mul_lo", result_o, 32'hFFFF_FFF1);
    @(posedge clk_i); #1;
    chk1("mul_no_extra_done", done_o, 1'b0);

    issue(4'b0010, 3'b000, 1'b0, 32'd1, 32'd1, 5'd0);
    chk32("hi_hold", hi_o, 32'hFFFF_FFFF);

    issue(4'b1011, 3'b000, 1'b0, 32'h8000_0000, 32'h8000_0000, 5'd0);
    for (int i = 0; i < 40 && !done_o; i++) begin
      @(posedge clk_i); #1;
    end
    chk1("mulmin_done", done_o, 1'b1);
    chk32("mulmin_hi", hi_o, 32'h4000_0000);
    chk32("mulmin_lo", result_o, 32'h0);
    chk1("mulmin_zero", zero_o, 1'b1);
`else
    issue(4'b1011, 3'b000, 1'b0, 32'hFFFF_FFFD, 32'h0000_0005, 5'd0);
    chk1("mul_off_done", done_o, 1'b1);
    chk1("mul_off_busy", busy_o, 1'b0);
    chk32("mul_off_lo", result_o, 32'h0);
    chk32("mul_off_hi", hi_o, 32'h0);
`endif

    // Reset during a multiply (or after it, when the multiplier is absent).
    issue(4'b1011, 3'b000, 1'b0, 32'd7, 32'd9, 5'd0);
    repeat (9) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    chk32("midrst_result", result_o, 32'h0);
    chk32("midrst_hi", hi_o, 32'h0);
    chk1("midrst_zero", zero_o, 1'b0);
    chk1("midrst_ovf", overflow_o, 1'b0);
    chk1("midrst_busy", busy_o, 1'b0);
    chk1("midrst_done", done_o, 1'b0);
    @(negedge clk_i); rst_i = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      if (done_o) done_seen++;
    end
    chk32("midrst_no_done", done_seen, 32'd0);

    issue(4'b0010, 3'b000, 1'b0, 32'd2, 32'd3, 5'd0);
    chk1("post_rst_done", done_o, 1'b1);
    chk32("post_rst_add", result_o, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
